// File: rtl/vx_mem_rsp_arb_pkg.sv
// Shared helpers for the memory-response arbiter and its round-robin picker.
package vx_mem_rsp_arb_pkg;

  localparam int unsigned DEF_NUM_REQS   = 4;
  localparam int unsigned DEF_DATA_WIDTH = 512;
  localparam int unsigned DEF_TAG_WIDTH  = 8;

  // Index width for n requesters; never below one bit so a single requester still has an index field.
  function automatic int unsigned log_num_reqs(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Modular increment with an explicit wrap, valid for non-power-of-2 n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return ((ptr + 1) >= n) ? 0 : (ptr + 1);
  endfunction

endpackage

// File: rtl/vx_rr_pick.sv
// Combinational round-robin priority picker: first valid requester at or after ptr_i, wrapping.
module vx_rr_pick
  import vx_mem_rsp_arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned LOGN = log_num_reqs(N)
) (
  input  logic [N-1:0]    valid_i,
  input  logic [LOGN-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [LOGN-1:0] idx_o,
  output logic            any_o
);

  // Two passes: requesters at/after the pointer first, then the wrapped-around low requesters.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_o && valid_i[i] && (i >= 32'(ptr_i))) begin
        grant_o[i] = 1'b1;
        idx_o      = LOGN'(i);
        any_o      = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_o && valid_i[i]) begin
        grant_o[i] = 1'b1;
        idx_o      = LOGN'(i);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_mem_rsp_arb.sv
// Round-robin merge of NUM_REQS response streams onto one channel, winner index prepended to the tag.
// Build option: VX_MEM_RSP_ARB_OUT_BUF_EN selects a registered 2-entry skid output stage;
// otherwise the output is a zero-latency combinational bypass with a grant lock under backpressure.
module vx_mem_rsp_arb
  import vx_mem_rsp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQS     = DEF_NUM_REQS,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned TAG_WIDTH    = DEF_TAG_WIDTH,
  parameter int unsigned LOG_NUM_REQS = log_num_reqs(NUM_REQS)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQS-1:0]               rsp_in_valid,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]    rsp_in_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]     rsp_in_tag,
  output logic [NUM_REQS-1:0]               rsp_in_ready,
  output logic                              rsp_out_valid,
  output logic [DATA_WIDTH-1:0]             rsp_out_data,
  output logic [TAG_WIDTH+LOG_NUM_REQS-1:0] rsp_out_tag,
  input  logic                              rsp_out_ready
);

  localparam int unsigned OUT_TAG_W = TAG_WIDTH + LOG_NUM_REQS;

  logic [LOG_NUM_REQS-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_REQS-1:0]     pick_grant;
  logic [LOG_NUM_REQS-1:0] pick_idx;
  logic                    pick_any;
  logic [LOG_NUM_REQS-1:0] sel_idx;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [TAG_WIDTH-1:0]    sel_tag;
  logic                    out_fire;

  vx_rr_pick #(
    .N    (NUM_REQS),
    .LOGN (LOG_NUM_REQS)
  ) u_pick (
    .valid_i (rsp_in_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Slice out the selected requester's data and tag.
  always_comb begin
    sel_data = '0;
    sel_tag  = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (sel_idx == LOG_NUM_REQS'(i)) begin
        sel_data = rsp_in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tag  = rsp_in_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef VX_MEM_RSP_ARB_OUT_BUF_EN

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [OUT_TAG_W-1:0]  main_tag_q, main_tag_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [OUT_TAG_W-1:0]  skid_tag_q, skid_tag_d;
  logic                  in_fire;

  assign sel_idx       = pick_idx;
  assign rsp_out_valid = main_valid_q;
  assign rsp_out_data  = main_data_q;
  assign rsp_out_tag   = main_tag_q;

  // Skid-buffer fill/drain; input ready depends only on skid occupancy, never on rsp_out_ready.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    rr_ptr_d     = rr_ptr_q;
    in_fire      = reset_n & pick_any & ~skid_valid_q;
    out_fire     = main_valid_q & rsp_out_ready;
    rsp_in_ready = (reset_n && !skid_valid_q) ? pick_grant : '0;
    if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = sel_data;
        main_tag_d   = {sel_idx, sel_tag};
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = sel_data;
      skid_tag_d   = {sel_idx, sel_tag};
    end
    if (in_fire) begin
      rr_ptr_d = LOG_NUM_REQS'(rr_next(32'(sel_idx), NUM_REQS));
    end
  end

  // Main and skid entry registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

`else

  logic                    locked_q, locked_d;
  logic [LOG_NUM_REQS-1:0] lock_idx_q, lock_idx_d;
  logic [NUM_REQS-1:0]     lock_grant;
  logic                    sel_valid;

  // Bypass path: present the locked requester if stalled, otherwise the fresh round-robin winner.
  always_comb begin
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    lock_grant = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      lock_grant[i] = (lock_idx_q == LOG_NUM_REQS'(i));
    end
    sel_idx       = locked_q ? lock_idx_q : pick_idx;
    sel_valid     = reset_n & (locked_q | pick_any);
    out_fire      = sel_valid & rsp_out_ready;
    rsp_in_ready  = '0;
    if (out_fire) begin
      rsp_in_ready = locked_q ? lock_grant : pick_grant;
    end
    rsp_out_valid = sel_valid;
    rsp_out_data  = sel_data;
    rsp_out_tag   = {sel_idx, sel_tag};
    if (out_fire) begin
      locked_d = 1'b0;
      rr_ptr_d = LOG_NUM_REQS'(rr_next(32'(sel_idx), NUM_REQS));
    end else if (sel_valid) begin
      locked_d   = 1'b1;
      lock_idx_d = sel_idx;
    end
  end

  // Grant-lock registers holding the stalled winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`endif

endmodule

// File: tb/tb_vx_mem_rsp_arb.sv
// Self-checking bench for vx_mem_rsp_arb (4 requesters, plus a 3-requester instance).
module tb_vx_mem_rsp_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned TW  = 8;
  localparam int unsigned OTW = TW + 2;
`ifdef VX_MEM_RSP_ARB_OUT_BUF_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    rsp_in_valid;
  logic [N*DW-1:0] rsp_in_data;
  logic [N*TW-1:0] rsp_in_tag;
  logic [N-1:0]    rsp_in_ready;
  logic            rsp_out_valid;
  logic [DW-1:0]   rsp_out_data;
  logic [OTW-1:0]  rsp_out_tag;
  logic            rsp_out_ready;

  logic [2:0]      v3;
  logic [3*DW-1:0] d3;
  logic [3*TW-1:0] t3;
  logic [2:0]      r3;
  logic            ov3;
  logic [DW-1:0]   od3;
  logic [OTW-1:0]  ot3;

  vx_mem_rsp_arb #(.NUM_REQS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .rsp_in_valid(rsp_in_valid), .rsp_in_data(rsp_in_data), .rsp_in_tag(rsp_in_tag),
    .rsp_in_ready(rsp_in_ready),
    .rsp_out_valid(rsp_out_valid), .rsp_out_data(rsp_out_data), .rsp_out_tag(rsp_out_tag),
    .rsp_out_ready(rsp_out_ready)
  );

  vx_mem_rsp_arb #(.NUM_REQS(3), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .rsp_in_valid(v3), .rsp_in_data(d3), .rsp_in_tag(t3), .rsp_in_ready(r3),
    .rsp_out_valid(ov3), .rsp_out_data(od3), .rsp_out_tag(ot3),
    .rsp_out_ready(rsp_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic           ov;
    logic           eov;
    logic [OTW-1:0] otag;
    logic [OTW-1:0] etag;
    logic [DW-1:0]  odata;
    logic [DW-1:0]  edata;
    logic [N-1:0]   irdy;
    logic [N-1:0]   erdy;
  } cyc_t;

  typedef struct packed {
    logic [OTW-1:0] tag;
    logic [DW-1:0]  data;
  } xfer_t;

  cyc_t       log_q[$];
  xfer_t      acc_q[$];
  xfer_t      out_q[$];
  xfer_t      mq[$];
  logic [1:0] q3[$];

  int            rem[N];
  logic [DW-1:0] hd[N];
  logic [TW-1:0] ht[N];
  bit            refill;

  int m_ptr;
  bit m_locked;
  int m_win;

  int n_checks;
  int n_errors;

  // Reference arbitration rule: first valid requester at or after ptr, modulo N.
  function automatic int rrpick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      rsp_in_valid[i]          = (rem[i] > 0);
      rsp_in_data[i*DW +: DW]  = hd[i];
      rsp_in_tag[i*TW +: TW]   = ht[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_locked = 0;
    m_win = 0;
    mq.delete();
    log_q.delete();
    acc_q.delete();
    out_q.delete();
    q3.delete();
  endtask

  // One clock: drive sources, predict, sample at negedge, apply handshakes after the edge.
  task automatic step(input logic rdy);
    cyc_t         c;
    logic [N-1:0] v;
    logic [N-1:0] fired;
    int           w;
    c = '0;
    w = 0;
    rsp_out_ready = rdy;
    drive();
    v = rsp_in_valid;
`ifdef VX_MEM_RSP_ARB_OUT_BUF_EN
    c.eov = (mq.size() > 0);
    if (c.eov) begin
      c.etag  = mq[0].tag;
      c.edata = mq[0].data;
    end
    if (mq.size() < 2 && v != 0) begin
      w = rrpick(m_ptr, v);
      c.erdy = N'(1) << w;
    end
`else
    if (!m_locked && v != 0) m_win = rrpick(m_ptr, v);
    c.eov = m_locked || (v != 0);
    if (c.eov) begin
      c.etag  = {2'(m_win), ht[m_win]};
      c.edata = hd[m_win];
      if (rdy) c.erdy = N'(1) << m_win;
    end
`endif
    @(negedge clk);
    c.ov    = rsp_out_valid;
    c.otag  = rsp_out_tag;
    c.odata = rsp_out_data;
    c.irdy  = rsp_in_ready;
    log_q.push_back(c);
    fired = v & rsp_in_ready;
    for (int i = 0; i < N; i++) begin
      if (fired[i]) acc_q.push_back(xfer_t'({2'(i), ht[i], hd[i]}));
    end
    if (rsp_out_valid && rdy) out_q.push_back(xfer_t'({rsp_out_tag, rsp_out_data}));
    if (ov3 && rdy) q3.push_back(ot3[OTW-1 -: 2]);
    @(posedge clk);
    #1;
`ifdef VX_MEM_RSP_ARB_OUT_BUF_EN
    if (c.eov && rdy) void'(mq.pop_front());
    if (c.erdy != 0) begin
      mq.push_back(xfer_t'({2'(w), ht[w], hd[w]}));
      m_ptr = (w + 1) % N;
    end
`else
    if (c.eov) begin
      if (rdy) begin
        m_ptr = (m_win + 1) % N;
        m_locked = 0;
      end else begin
        m_locked = 1;
      end
    end
`endif
    for (int i = 0; i < N; i++) begin
      if (fired[i]) begin
        rem[i] = rem[i] - 1;
        hd[i]  = $urandom;
        ht[i]  = TW'($urandom);
      end else if (refill && rem[i] == 0 && $urandom_range(0, 3) == 0) begin
        rem[i] = $urandom_range(1, 3);
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      hd[i]  = $urandom;
      ht[i]  = TW'($urandom);
    end
    v3 = '0;
    refill = 0;
    rsp_out_ready = 1'b0;
    drive();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) rem[i] = 10;
    drive();
    v3 = '1;
    rsp_out_ready = 1'b1;
    #1;
    n_checks++;
    if (rsp_out_valid !== 1'b0 || rsp_in_ready !== '0 || ov3 !== 1'b0 || r3 !== '0) begin
      n_errors++;
      $display("FAIL reset_hold: out_valid=%b in_ready=%b (n3 %b %b), want 0", rsp_out_valid, rsp_in_ready, ov3, r3);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    drive();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_out_valid !== 1'b0 || rsp_in_ready !== '0 || ov3 !== 1'b0 || r3 !== '0) begin
      n_errors++;
      $display("FAIL reset_async: out_valid=%b in_ready=%b (n3 %b %b), want 0", rsp_out_valid, rsp_in_ready, ov3, r3);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    repeat (3) step(1'b1);
    n_checks++;
    if (out_q.size() == 0) begin
      n_errors++;
      $display("FAIL reset_first_grant: no output, want index 0");
    end else if (out_q[0].tag[OTW-1 -: 2] !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_first_grant: index %0d, want 0", out_q[0].tag[OTW-1 -: 2]);
    end
  endtask

  task automatic test_fairness();
    int cnt[N];
    do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 1000;
      cnt[i] = 0;
    end
    repeat (16 + LAT) step(1'b1);
    n_checks++;
    if (out_q.size() != 16) begin
      n_errors++;
      $display("FAIL fair_throughput: %0d outputs, want 16", out_q.size());
    end
    for (int k = 0; k < out_q.size(); k++) begin
      n_checks++;
      if (out_q[k].tag[OTW-1 -: 2] !== 2'(k % 4)) begin
        n_errors++;
        $display("FAIL fair_seq[%0d]: index %0d, want %0d", k, out_q[k].tag[OTW-1 -: 2], k % 4);
      end
      cnt[out_q[k].tag[OTW-1 -: 2]]++;
      if (k < acc_q.size()) begin
        n_checks++;
        if (out_q[k] !== acc_q[k]) begin
          n_errors++;
          $display("FAIL fair_data[%0d]: got %h, want %h", k, out_q[k], acc_q[k]);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (cnt[i] != 4) begin
        n_errors++;
        $display("FAIL fair_count[%0d]: %0d grants, want 4", i, cnt[i]);
      end
    end
  endtask

  task automatic test_tag_append();
    logic [DW-1:0]  d;
    logic [OTW-1:0] exp_tag;
    do_reset();
    rem[2] = 1;
    ht[2]  = 8'hA5;
    hd[2]  = $urandom;
    d = hd[2];
    exp_tag = {2'b10, 8'hA5};
    repeat (3) step(1'b1);
    n_checks++;
    if (out_q.size() != 1) begin
      n_errors++;
      $display("FAIL tag_count: %0d outputs, want 1", out_q.size());
    end else begin
      n_checks++;
      if (out_q[0].tag !== exp_tag) begin
        n_errors++;
        $display("FAIL tag_append: tag %h, want %h", out_q[0].tag, exp_tag);
      end
      if (out_q[0].data !== d) begin
        n_errors++;
        $display("FAIL tag_data: data %h, want %h", out_q[0].data, d);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d3s;
    do_reset();
    rem[3] = 1;
    d3s = hd[3];
    for (int k = 0; k < 8; k++) begin
      if (k == 2) rem[0] = 1;
      step(k >= 5);
    end
    for (int k = LAT; k < 5; k++) begin
      n_checks++;
      if (log_q[k].ov !== 1'b1 || log_q[k].otag[OTW-1 -: 2] !== 2'd3 || log_q[k].odata !== d3s) begin
        n_errors++;
        $display("FAIL lock_hold[%0d]: ov=%b idx=%0d data=%h, want 1 3 %h", k, log_q[k].ov, log_q[k].otag[OTW-1 -: 2], log_q[k].odata, d3s);
      end
`ifndef VX_MEM_RSP_ARB_OUT_BUF_EN
      n_checks++;
      if (log_q[k].irdy !== '0) begin
        n_errors++;
        $display("FAIL lock_ready[%0d]: in_ready=%b, want 0000", k, log_q[k].irdy);
      end
`endif
    end
    n_checks++;
    if (out_q.size() != 2) begin
      n_errors++;
      $display("FAIL lock_count: %0d outputs, want 2", out_q.size());
    end else begin
      n_checks++;
      if (out_q[0].tag[OTW-1 -: 2] !== 2'd3 || out_q[0].data !== d3s || out_q[1].tag[OTW-1 -: 2] !== 2'd0) begin
        n_errors++;
        $display("FAIL lock_order: idx %0d then %0d, want 3 then 0", out_q[0].tag[OTW-1 -: 2], out_q[1].tag[OTW-1 -: 2]);
      end
    end
  endtask

  task automatic test_skid();
    logic pat[5];
    int   per_src[N];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    rem[0] = 3;
    rem[1] = 3;
    for (int i = 0; i < N; i++) per_src[i] = 0;
    for (int k = 0; k < 5; k++) step(pat[k]);
    repeat (8) step(1'b1);
    foreach (log_q[k]) begin
      n_checks++;
      if (log_q[k].ov !== log_q[k].eov || log_q[k].irdy !== log_q[k].erdy ||
          (log_q[k].eov && (log_q[k].otag !== log_q[k].etag || log_q[k].odata !== log_q[k].edata))) begin
        n_errors++;
        $display("FAIL skid_cyc[%0d]: ov=%b tag=%h data=%h rdy=%b, want ov=%b tag=%h data=%h rdy=%b", k,
                 log_q[k].ov, log_q[k].otag, log_q[k].odata, log_q[k].irdy,
                 log_q[k].eov, log_q[k].etag, log_q[k].edata, log_q[k].erdy);
      end
    end
    n_checks++;
    if (out_q.size() != 6 || acc_q.size() != 6) begin
      n_errors++;
      $display("FAIL skid_count: out %0d acc %0d, want 6 6", out_q.size(), acc_q.size());
    end
    for (int k = 0; k < out_q.size() && k < acc_q.size(); k++) begin
      n_checks++;
      if (out_q[k] !== acc_q[k]) begin
        n_errors++;
        $display("FAIL skid_order[%0d]: got %h, want %h", k, out_q[k], acc_q[k]);
      end
      per_src[out_q[k].tag[OTW-1 -: 2]]++;
    end
    n_checks++;
    if (per_src[0] != 3 || per_src[1] != 3) begin
      n_errors++;
      $display("FAIL skid_per_src: src0 %0d src1 %0d, want 3 3", per_src[0], per_src[1]);
    end
  endtask

  task automatic test_npot();
    do_reset();
    d3 = {3{32'hC0DE_0000}} ^ {$urandom, $urandom, $urandom};
    t3 = 24'h12_34_56;
    v3 = '1;
    repeat (7) step(1'b1);
    n_checks++;
    if (q3.size() < 6) begin
      n_errors++;
      $display("FAIL npot_count: %0d outputs, want >= 6", q3.size());
    end
    for (int k = 0; k < q3.size(); k++) begin
      n_checks++;
      if (q3[k] !== 2'(k % 3)) begin
        n_errors++;
        $display("FAIL npot_seq[%0d]: index %0d, want %0d", k, q3[k], k % 3);
      end
    end
    v3 = '0;
  endtask

  task automatic test_random();
    do_reset();
    refill = 1;
    for (int i = 0; i < N; i++) rem[i] = $urandom_range(0, 3);
    repeat (300) step($urandom_range(0, 3) != 0);
    refill = 0;
    repeat (20) step(1'b1);
    foreach (log_q[k]) begin
      n_checks++;
      if (log_q[k].ov !== log_q[k].eov || log_q[k].irdy !== log_q[k].erdy ||
          (log_q[k].eov && (log_q[k].otag !== log_q[k].etag || log_q[k].odata !== log_q[k].edata))) begin
        n_errors++;
        $display("FAIL rand_cyc[%0d]: ov=%b tag=%h data=%h rdy=%b, want ov=%b tag=%h data=%h rdy=%b", k,
                 log_q[k].ov, log_q[k].otag, log_q[k].odata, log_q[k].irdy,
                 log_q[k].eov, log_q[k].etag, log_q[k].edata, log_q[k].erdy);
      end
    end
    n_checks++;
    if (out_q.size() != acc_q.size()) begin
      n_errors++;
      $display("FAIL rand_count: out %0d, want %0d", out_q.size(), acc_q.size());
    end
    for (int k = 0; k < out_q.size() && k < acc_q.size(); k++) begin
      n_checks++;
      if (out_q[k] !== acc_q[k]) begin
        n_errors++;
        $display("FAIL rand_order[%0d]: got %h, want %h", k, out_q[k], acc_q[k]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    refill = 0;
    rsp_out_ready = 1'b0;
    rsp_in_valid = '0;
    rsp_in_data = '0;
    rsp_in_tag = '0;
    v3 = '0;
    d3 = '0;
    t3 = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      hd[i]  = $urandom;
      ht[i]  = TW'($urandom);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fairness();
    test_tag_append();
    test_backpressure();
    test_skid();
    test_npot();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vx_mem_rsp_arb.md
# vx_mem_rsp_arb

Round-robin arbiter that merges NUM_REQS memory-response streams (valid/data/tag/ready) onto one response channel. It appends the winning requester index to the tag so a downstream demux can route the response back. It sits between the per-bank or per-port response sources and a single shared consumer, such as a cache fill port or the core memory unit. It provides fair sharing, holds the grant stable under backpressure, and optionally adds a registered elastic output stage.

## Interface
Parameters:
- NUM_REQS, 4, number of input response streams (≥1)
- DATA_WIDTH, 512, response data width
- TAG_WIDTH, 8, input tag width
- LOG_NUM_REQS, derived, max(1, $clog2(NUM_REQS))

Ports:
- clk  in  1  clock. One clock domain.
- reset_n  in  1  asynchronous active-low reset
- rsp_in_valid  in  NUM_REQS  per-requester valid
- rsp_in_data  in  NUM_REQS*DATA_WIDTH  requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- rsp_in_tag  in  NUM_REQS*TAG_WIDTH  packed the same way as rsp_in_data
- rsp_in_ready  out  NUM_REQS  per-requester ready
- rsp_out_valid  out  1  merged valid
- rsp_out_data  out  DATA_WIDTH  winner's data
- rsp_out_tag  out  TAG_WIDTH+LOG_NUM_REQS  {winner index, winner tag}; index in the MSBs
- rsp_out_ready  in  1  consumer ready

## Operation
- A transfer occurs on any channel when valid & ready are both high at the rising edge of clk.
- Input rules:
  - Sources hold valid, data and tag stable until accepted.
  - The arbiter never asserts rsp_in_ready[i] for more than one i in a cycle.
- Round-robin pointer `rr_ptr` (LOG_NUM_REQS bits):
  - The winner is the first valid requester at or after rr_ptr, modulo NUM_REQS.
  - On an accepted input transfer, rr_ptr ← winner+1. It wraps NUM_REQS-1 → 0; for non-power-of-2 NUM_REQS the wrap is explicit.
- Grant lock (bypass mode):
  - If the output is valid but not accepted, `locked` is set and `lock_idx` is held at the winner.
  - On the next cycles the same requester is presented, even if a higher-priority valid appears.
  - `locked` clears on the accepting edge.
- NUM_REQS=1:
  - Data and tag pass straight through, with index bit 0.
  - rr_ptr stays 0.
- Output-stage behaviour depends on VX_MEM_RSP_ARB_OUT_BUF_EN (see Configuration).

## Timing
- Reset values (asynchronous on reset_n low): rr_ptr=0, locked=0, lock_idx=0, rsp_out_valid=0, rsp_in_ready=0, buffer entries empty.
- rsp_out_data and rsp_out_tag are don't-care while rsp_out_valid=0.
- Bypass mode:
  - Latency 0. rsp_in_ready[winner] = rsp_out_ready.
  - Combinational path from valid/ready to ready.
- Buffered mode:
  - Latency 1 cycle. Full throughput of 1 response per cycle with a continuously ready consumer.
  - rsp_in_ready[winner] = !skid_full.
  - No combinational path from rsp_out_ready to rsp_in_ready.
- Simultaneous events:
  - All inputs valid: grant sequence is 0,1,2,3,0…
  - The buffer accepts and drains in the same cycle when occupancy is 1.
- Reset mid-transfer: any buffered or locked response is dropped. Sources must replay, which is the system-level responsibility.

## Configuration
- VX_MEM_RSP_ARB_OUT_BUF_EN defined:
  - The output is driven from a 2-entry skid buffer: a main register plus a skid register.
  - All outputs are registered.
  - The grant lock is unnecessary and not instantiated. Arbitration advances whenever the buffer accepts.
- Undefined:
  - Combinational bypass output with the grant lock described above.
  - Zero added latency.

## Structure
- Shared package `vx_mem_rsp_arb_pkg`:
  - function `rr_next(ptr, n)` for modular increment.
  - localparam helper for LOG_NUM_REQS (min 1).
- Sub-module `vx_rr_pick`: combinational round-robin priority picker.
  - Inputs: valid vector and pointer.
  - Outputs: one-hot grant, index, any_valid.
  - Reusable by the matching request-side arbiter.
- The skid buffer is inline in the top module, under the macro.

## Test plan
- Reset:
  - Assert reset_n=0 mid-stream.
  - Required: rsp_out_valid=0 and rsp_in_ready=0 immediately, without waiting for a clk edge.
  - Required: after release, the first grant goes to requester 0.
- Fairness:
  - All 4 requesters valid continuously; rsp_out_ready=1; 16 cycles.
  - Required: out index sequence 0,1,2,3 repeated, each exactly 4 times.
  - Required: throughput 1 per cycle in both modes.
- Tag append:
  - Requester 2 only, tag 0xA5.
  - Required: rsp_out_tag = {2'b10, 8'hA5} and data is passed intact.
- Backpressure lock (bypass):
  - Requester 3 is valid and rsp_out_ready=0 for 5 cycles.
  - Requester 0 becomes valid in cycle 2.
  - Required: output stays requester 3 with stable data until accepted, then requester 0 is granted.
- Skid buffer (buffered):
  - Toggle rsp_out_ready 1,0,0,1,1 with 2 sources valid.
  - Required: no loss or duplication; in-order-per-source delivery.
  - Required: rsp_in_ready drops only while 2 entries are held.
- Non-power-of-2 (NUM_REQS=3):
  - All valid.
  - Required: index sequence 0,1,2,0 with no illegal index 3.
